// File: rtl/drowsiness_pkg.sv
// ----------------------------------------------------------------------------
// drowsiness_pkg
// Shared constants and types for the drowsiness-detection front end.
//   N_FEAT_DEF  : feature entries per window
//   W_DEF       : bit width of raw samples and averaged entries
//   N_AVG_DEF   : raw samples averaged into one entry (power of two)
//   fwb_state_e : feature_window_buffer FSM state encoding (drives the LEDs)
// ----------------------------------------------------------------------------
package drowsiness_pkg;

    localparam int N_FEAT_DEF = 30;
    localparam int W_DEF      = 10;
    localparam int N_AVG_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_BUSY   = 2'd3
    } fwb_state_e;

    // Shift amount that turns an N_AVG-sample sum into an average.
    function automatic int avg_shift(input int n_avg);
        return $clog2(n_avg);
    endfunction

endpackage

// File: rtl/sample_averager.sv
// ----------------------------------------------------------------------------
// sample_averager
// Sums N_AVG qualified samples and emits their truncated mean.
//   clk, rst       : clock, asynchronous active-high reset
//   clear          : drop any partial sum (wins over sample_valid)
//   sample_valid   : sample_in is to be accumulated this cycle
//   sample_in      : raw unsigned sample
//   entry_value    : (acc + sample_in) >> log2(N_AVG), valid with entry_strobe
//   entry_strobe   : this cycle's sample completes a group of N_AVG
// ----------------------------------------------------------------------------
module sample_averager
    import drowsiness_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int N_AVG = N_AVG_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         sample_valid,
    input  logic [W-1:0] sample_in,
    output logic [W-1:0] entry_value,
    output logic         entry_strobe
);

    localparam int SH = avg_shift(N_AVG);
    localparam int AW = W + SH;
    localparam int CW = (SH > 0) ? SH : 1;

    logic [AW-1:0] acc_q, acc_d, sum;
    logic [CW-1:0] sub_q, sub_d;
    logic          last;

    always_comb begin
        // AW bits hold N_AVG full-scale samples, so the sum cannot wrap.
        sum          = acc_q + AW'(sample_in);
        last         = (sub_q == CW'(N_AVG - 1));
        entry_value  = sum[AW-1:SH];
        entry_strobe = sample_valid && !clear && last;
        acc_d        = acc_q;
        sub_d        = sub_q;
        if (clear) begin
            acc_d = '0;
            sub_d = '0;
        end else if (sample_valid) begin
            if (last) begin
                acc_d = '0;
                sub_d = '0;
            end else begin
                acc_d = sum;
                sub_d = sub_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            sub_q <= '0;
        end else begin
            acc_q <= acc_d;
            sub_q <= sub_d;
        end
    end

endmodule

// File: rtl/feature_window_buffer.sv
// ----------------------------------------------------------------------------
// feature_window_buffer
// Double-buffered feature window for the drowsiness detector. Raw samples are
// averaged in groups of N_AVG into a fill buffer; once N_FEAT entries are in,
// the fill buffer is copied to the shadow window and start_ann pulses. While
// the detector works (BUSY) the next window fills behind the stable shadow.
//   Clock, Rst    : clock, asynchronous active-high reset
//   en            : capture enable; low returns to IDLE discarding partial fill
//   sample_in     : raw unsigned sample, qualified by sample_valid
//   ann_done      : detector has consumed the current window (level, BUSY only)
//   window        : launched window, N_FEAT entries of W bits
//   window_valid  : window holds a complete launched set
//   start_ann     : one-cycle launch pulse (high during LAUNCH)
//   fill_count    : entries written into the fill buffer
//   state         : FSM state (IDLE=0 FILL=1 LAUNCH=2 BUSY=3)
//   overrun       : sticky, a sample arrived while the fill buffer was full
// ----------------------------------------------------------------------------
module feature_window_buffer
    import drowsiness_pkg::*;
#(
    parameter int N_FEAT = N_FEAT_DEF,
    parameter int W      = W_DEF,
    parameter int N_AVG  = N_AVG_DEF
) (
    input  logic         Clock,
    input  logic         Rst,
    input  logic         en,
    input  logic [W-1:0] sample_in,
    input  logic         sample_valid,
    input  logic         ann_done,
    output logic [W-1:0] window [0:N_FEAT-1],
    output logic         window_valid,
    output logic         start_ann,
    output logic [4:0]   fill_count,
    output logic [1:0]   state,
    output logic         overrun
);

    localparam logic [4:0] FULL_CNT = 5'(N_FEAT);

    fwb_state_e   state_q, state_d;
    logic [4:0]   fill_count_q, fill_count_d;
    logic [W-1:0] fill_q   [0:N_FEAT-1];
    logic [W-1:0] window_q [0:N_FEAT-1];
    logic         window_valid_q;
    logic         overrun_q, overrun_d;

    logic         fill_full;
    logic         full_next;
    logic         capturing;
    logic         clear_fill;
    logic         launching;
    logic         entry_strobe;
    logic [W-1:0] entry_value;

    always_comb begin
        fill_full  = (fill_count_q == FULL_CNT);
        capturing  = en && sample_valid && !fill_full &&
                     (state_q == ST_FILL || state_q == ST_BUSY);
        // Leaving for IDLE or launching both restart the fill from entry 0.
        clear_fill = (state_q != ST_IDLE && !en) || (state_q == ST_LAUNCH);
        launching  = (state_q == ST_LAUNCH) && en;
        // A last entry landing together with ann_done still counts as full.
        full_next  = fill_full || (entry_strobe && fill_count_q == FULL_CNT - 5'd1);
    end

    sample_averager #(
        .W     (W),
        .N_AVG (N_AVG)
    ) u_avg (
        .clk          (Clock),
        .rst          (Rst),
        .clear        (clear_fill),
        .sample_valid (capturing),
        .sample_in    (sample_in),
        .entry_value  (entry_value),
        .entry_strobe (entry_strobe)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (en) state_d = ST_FILL;
            ST_FILL: begin
                if (!en)            state_d = ST_IDLE;
                else if (fill_full) state_d = ST_LAUNCH;
            end
            ST_LAUNCH: state_d = en ? ST_BUSY : ST_IDLE;
            ST_BUSY: begin
                if (!en)           state_d = ST_IDLE;
                else if (ann_done) state_d = full_next ? ST_LAUNCH : ST_FILL;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fill_count_d = fill_count_q;
        if (clear_fill)        fill_count_d = '0;
        else if (entry_strobe) fill_count_d = fill_count_q + 5'd1;
        overrun_d = overrun_q | (en && sample_valid && fill_full && state_q != ST_IDLE);
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            state_q        <= ST_IDLE;
            fill_count_q   <= '0;
            window_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_count_q <= fill_count_d;
            overrun_q    <= overrun_d;
            if (launching) window_valid_q <= 1'b1;
        end
    end

    // Fill storage needs no reset: fill_count governs what is meaningful.
    always_ff @(posedge Clock) begin
        if (entry_strobe) fill_q[fill_count_q] <= entry_value;
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < N_FEAT; i++) window_q[i] <= '0;
        end else if (launching) begin
            for (int i = 0; i < N_FEAT; i++) window_q[i] <= fill_q[i];
        end
    end

    assign window       = window_q;
    assign window_valid = window_valid_q;
    assign start_ann    = launching;
    assign fill_count   = fill_count_q;
    assign state        = state_q;
    assign overrun      = overrun_q;

endmodule

// File: doc/feature_window_buffer.md
FEATURE_WINDOW_BUFFER -- requirements
Module: feature_window_buffer

Interface
REQ-001 SHALL have parameter N_FEAT, default 30, the number of feature entries per window.
REQ-002 SHALL have parameter W, default 10, the bit width of each sample and each entry.
REQ-003 SHALL have parameter N_AVG, default 4 (a power of two), the number of raw samples averaged into one entry.
REQ-004 SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port en, input, 1 bit: capture enable.
REQ-007 SHALL have port sample_in, input, W bits: raw unsigned sample.
REQ-008 SHALL have port sample_valid, input, 1 bit: sample_in is qualified this cycle.
REQ-009 SHALL have port ann_done, input, 1 bit: level from the downstream detector; the current window has been consumed.
REQ-010 SHALL have port window, output, unpacked array [0:N_FEAT-1] of W bits: the launched window that feeds the detector in1.
REQ-011 SHALL have port window_valid, output, 1 bit: window holds a complete launched set.
REQ-012 SHALL have port start_ann, output, 1 bit: one-cycle launch pulse that drives the detector Start.
REQ-013 SHALL have port fill_count, output, 5 bits: number of entries written into the fill buffer.
REQ-014 SHALL have port state, output, 2 bits: FSM state for the LEDs.
REQ-015 SHALL have port overrun, output, 1 bit: sticky flag, set when samples are dropped.

Function
REQ-016 SHALL be double-buffered: a fill buffer of N_FEAT entries plus a shadow window register feeding the window output.
REQ-017 SHALL accumulate, in FILL or BUSY with the fill buffer not full, each sample_valid sample into a (W+log2 N_AVG)-bit accumulator; on the N_AVG-th sample it SHALL write (acc+sample_in)>>log2(N_AVG) (truncating) to fill[fill_count], increment fill_count, and clear the accumulator and sub-count.
REQ-018 SHALL implement the FSM states IDLE=0, FILL=1, LAUNCH=2, BUSY=3.
REQ-019 SHALL transition IDLE->FILL when en=1.
REQ-020 SHALL transition FILL->LAUNCH on the cycle after fill_count reaches N_FEAT.
REQ-021 SHALL, in LAUNCH, copy fill into window, set window_valid=1, assert start_ann for exactly this one cycle, clear fill_count, the accumulator and the sub-count, then go to BUSY.
REQ-022 SHALL, in BUSY, keep capturing into the fill buffer while the shadow window stays stable.
REQ-023 SHALL, in BUSY with ann_done=1, go to LAUNCH if fill_count==N_FEAT and otherwise go to FILL.
REQ-024 SHALL, when a sample_valid arrives while the fill buffer is full (BUSY, or the FILL->LAUNCH cycle), drop the sample and set overrun=1; overrun SHALL clear only on reset.
REQ-025 SHALL treat the sample that completes the last entry on the same cycle as ann_done as written; the next state is LAUNCH.
REQ-026 SHALL, when en=0 in any state other than IDLE, go to IDLE next cycle and clear fill_count, the accumulator and the sub-count, while window and window_valid are held.
REQ-027 SHALL give en=0 priority over a pending LAUNCH; start_ann is not asserted.
REQ-028 SHALL have a latency of 2 cycles from the sample_valid that completes entry N_FEAT-1 (in FILL) to the start_ann pulse.
REQ-029 SHALL ignore ann_done outside BUSY.

Reset
REQ-030 SHALL, while Rst=1, immediately force state=IDLE, fill_count=0, accumulator=0, sub-count=0, window entries=0, window_valid=0, start_ann=0, overrun=0.
REQ-031 SHALL, when Rst is asserted mid-window, discard partial data; no start_ann is issued.

Structure
REQ-032 SHALL take N_FEAT, W, N_AVG and the FSM state enum from the shared drowsiness package.
REQ-033 SHALL contain exactly one sub-module, sample_averager, holding the accumulator and sub-counter and emitting the entry value plus an entry_strobe.

Verification
REQ-034 SHALL cover: en=1, 120 valid samples all 200 -> start_ann single pulse 2 cycles after the 120th sample, all window entries 200, fill_count=0.
REQ-035 SHALL cover: groups of samples 3,4,5,6 -> entry value 4 (18>>2), truncation confirmed.
REQ-036 SHALL cover: BUSY, a further 120 samples then a 121st with ann_done=0 -> overrun=1, window unchanged; then ann_done=1 -> LAUNCH, new window loaded.
REQ-037 SHALL cover: the 120th sample and ann_done in the same cycle -> next state LAUNCH, start_ann 1 cycle later.
REQ-038 SHALL cover: en=0 after 50 samples -> IDLE, fill_count=0, window/window_valid retained; re-enable refills from entry 0.
REQ-039 SHALL cover: Rst pulse asynchronous to Clock mid-FILL -> all outputs 0 before the next Clock edge.
